life_evolve_engine: RTL and testbench

//  Row-serial, rule-programmable Game-of-Life generation engine for an N-column x M-row grid.

---
 rtl/life_pkg.sv | 22 ++
 rtl/life_row_eval.sv | 34 +++
 rtl/life_evolve_engine.sv | 136 +++++++++++++
 tb/tb_life_evolve_engine.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared types, constants and helpers for the life evolve engine
package life_pkg;

    typedef enum logic {IDLE, RUN} state_t;

    localparam int NBR_W = 4;
    localparam logic [8:0] LIFE_B3  = 9'h008;
    localparam logic [8:0] LIFE_S23 = 9'h00C;

    // Rows wider than POP_MAX_W cells are not supported by popcount.
    localparam int POP_MAX_W = 64;

    function automatic int unsigned popcount(input logic [POP_MAX_W-1:0] v);
        int unsigned c;
        c = 0;
        for (int i = 0; i < POP_MAX_W; i++) begin
            c = c + {31'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/life_row_eval.sv
// rtl/life_row_eval.sv - combinational next-state evaluation of one grid row
module life_row_eval
    import life_pkg::*;
#(
    parameter int P_PARAM_N = 5
) (
    input  logic [P_PARAM_N-1:0] above,
    input  logic [P_PARAM_N-1:0] cur,
    input  logic [P_PARAM_N-1:0] below,
    input  logic                 wrap,
    input  logic [8:0]           birth_mask,
    input  logic [8:0]           surv_mask,
    output logic [P_PARAM_N-1:0] nxt
);

    for (genvar j = 0; j < P_PARAM_N; j++) begin : g_col
        localparam int JL = (j == 0) ? P_PARAM_N - 1 : j - 1;
        localparam int JR = (j == P_PARAM_N - 1) ? 0 : j + 1;

        logic             lv;
        logic             rv;
        logic [NBR_W-1:0] cnt;

        // Edge columns only see their wrapped neighbour when wrap is on;
        // with N=2 the left and right neighbour alias and count twice.
        assign lv  = (j != 0) || wrap;
        assign rv  = (j != P_PARAM_N - 1) || wrap;
        assign cnt = NBR_W'(above[j]) + NBR_W'(below[j])
                   + NBR_W'(above[JL] & lv) + NBR_W'(cur[JL] & lv) + NBR_W'(below[JL] & lv)
                   + NBR_W'(above[JR] & rv) + NBR_W'(cur[JR] & rv) + NBR_W'(below[JR] & rv);
        assign nxt[j] = cur[j] ? surv_mask[cnt] : birth_mask[cnt];
    end

endmodule

// File: rtl/life_evolve_engine.sv
// rtl/life_evolve_engine.sv - row-serial rule-programmable Game-of-Life generation engine
module life_evolve_engine
    import life_pkg::*;
#(
    parameter int P_PARAM_N = 5,
    parameter int P_PARAM_M = 5,
    parameter int P_GEN_W   = 16
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   wrap,
    input  logic [8:0]                             birth_mask,
    input  logic [8:0]                             surv_mask,
    input  logic [P_PARAM_N*P_PARAM_M-1:0]         prev,
    output logic [P_PARAM_N*P_PARAM_M-1:0]         next,
    output logic                                   busy,
    output logic                                   done,
    output logic [P_GEN_W-1:0]                     gen_count,
    output logic [$clog2(P_PARAM_N*P_PARAM_M+1)-1:0] live_count,
    output logic                                   changed
);

    localparam int N      = P_PARAM_N;
    localparam int M      = P_PARAM_M;
    localparam int LIVE_W = $clog2(N*M+1);
    localparam int ROW_W  = $clog2(M);

    state_t            state;
    logic [ROW_W-1:0]  row;
    logic [N-1:0]      snap [M];
    logic [N-1:0]      next_rows [M];
    logic              wrap_q;
    logic [8:0]        birth_q;
    logic [8:0]        surv_q;
    logic [LIVE_W-1:0] live_acc;
    logic              chg_acc;

    logic [N-1:0]      above_r;
    logic [N-1:0]      cur_r;
    logic [N-1:0]      below_r;
    logic [N-1:0]      row_nxt;
    logic [LIVE_W-1:0] row_pop;
    logic              row_mism;
    logic              last_row;

    // Rows outside the grid are either the opposite edge (wrap) or all dead.
    always_comb begin
        last_row = (row == ROW_W'(M - 1));
        cur_r    = snap[row];
        above_r  = '0;
        below_r  = '0;
        if (row == '0) begin
            if (wrap_q) above_r = snap[M-1];
        end else begin
            above_r = snap[row - ROW_W'(1)];
        end
        if (last_row) begin
            if (wrap_q) below_r = snap[0];
        end else begin
            below_r = snap[row + ROW_W'(1)];
        end
    end

    life_row_eval #(.P_PARAM_N(N)) u_row_eval (
        .above      (above_r),
        .cur        (cur_r),
        .below      (below_r),
        .wrap       (wrap_q),
        .birth_mask (birth_q),
        .surv_mask  (surv_q),
        .nxt        (row_nxt)
    );

    assign row_pop  = LIVE_W'(popcount(POP_MAX_W'(row_nxt)));
    assign row_mism = |(row_nxt ^ cur_r);

    for (genvar i = 0; i < M; i++) begin : g_next
        assign next[i*N +: N] = next_rows[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            row        <= '0;
            wrap_q     <= 1'b0;
            birth_q    <= '0;
            surv_q     <= '0;
            live_acc   <= '0;
            chg_acc    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            gen_count  <= '0;
            live_count <= '0;
            changed    <= 1'b0;
            for (int i = 0; i < M; i++) begin
                snap[i]      <= '0;
                next_rows[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int i = 0; i < M; i++) snap[i] <= prev[i*N +: N];
                        wrap_q   <= wrap;
                        birth_q  <= birth_mask;
                        surv_q   <= surv_mask;
                        row      <= '0;
                        live_acc <= '0;
                        chg_acc  <= 1'b0;
                        busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    next_rows[row] <= row_nxt;
                    live_acc       <= live_acc + row_pop;
                    chg_acc        <= chg_acc | row_mism;
                    if (last_row) begin
                        live_count <= live_acc + row_pop;
                        changed    <= chg_acc | row_mism;
                        gen_count  <= gen_count + P_GEN_W'(1);
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        row <= row + ROW_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_life_evolve_engine.sv
// tb/tb_life_evolve_engine.sv - self-checking bench for life_evolve_engine on a 5x5 grid
module tb_life_evolve_engine;
    import life_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic        wrap;
    logic [8:0]  birth_mask;
    logic [8:0]  surv_mask;
    logic [24:0] prev;
    logic [24:0] next;
    logic        busy;
    logic        done;
    logic [15:0] gen_count;
    logic [4:0]  live_count;
    logic        changed;

    int checks   = 0;
    int failures = 0;
    int gen_exp  = 0;

    life_evolve_engine #(.P_PARAM_N(5), .P_PARAM_M(5), .P_GEN_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .wrap       (wrap),
        .birth_mask (birth_mask),
        .surv_mask  (surv_mask),
        .prev       (prev),
        .next       (next),
        .busy       (busy),
        .done       (done),
        .gen_count  (gen_count),
        .live_count (live_count),
        .changed    (changed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [24:0] prev;
        logic        wrap;
        logic [8:0]  birth;
        logic [8:0]  surv;
        logic [24:0] exp_next;
        logic [4:0]  exp_live;
        logic        exp_chg;
    } vec_t;

    vec_t vecs[6];

    localparam logic [24:0] BL_H = (25'd1 << 11) | (25'd1 << 12) | (25'd1 << 13);
    localparam logic [24:0] BL_V = (25'd1 << 7) | (25'd1 << 12) | (25'd1 << 17);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!done && k < 20) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
    endtask

    task automatic run_gen(input vec_t v);
        int k;
        @(negedge clk);
        prev = v.prev; wrap = v.wrap; birth_mask = v.birth; surv_mask = v.surv; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({v.name, " busy"}, 64'(busy), 64'd1);
        wait_done(k);
        gen_exp++;
        chk({v.name, " latency"}, 64'(k), 64'd5);
        chk({v.name, " next"}, 64'(next), 64'(v.exp_next));
        chk({v.name, " live"}, 64'(live_count), 64'(v.exp_live));
        chk({v.name, " changed"}, 64'(changed), 64'(v.exp_chg));
        chk({v.name, " gen"}, 64'(gen_count), 64'(gen_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int ndone;

        vecs[0] = '{"blinker", BL_H, 1'b0, LIFE_B3, LIFE_S23, BL_V, 5'd3, 1'b1};
        vecs[1] = '{"edge_wrap", (25'd1 << 10) | (25'd1 << 11) | (25'd1 << 14), 1'b1, LIFE_B3, LIFE_S23,
                    (25'd1 << 5) | (25'd1 << 10) | (25'd1 << 15), 5'd3, 1'b1};
        vecs[2] = '{"edge_nowrap", (25'd1 << 10) | (25'd1 << 11) | (25'd1 << 14), 1'b0, LIFE_B3, LIFE_S23,
                    25'd0, 5'd0, 1'b1};
        vecs[3] = '{"block", (25'd1 << 6) | (25'd1 << 7) | (25'd1 << 11) | (25'd1 << 12), 1'b0,
                    LIFE_B3, LIFE_S23, (25'd1 << 6) | (25'd1 << 7) | (25'd1 << 11) | (25'd1 << 12), 5'd4, 1'b0};
        vecs[4] = '{"custom", 25'd1 << 12, 1'b0, 9'h002, 9'h000,
                    (25'd1 << 6) | (25'd1 << 7) | (25'd1 << 8) | (25'd1 << 11) | (25'd1 << 13)
                    | (25'd1 << 16) | (25'd1 << 17) | (25'd1 << 18), 5'd8, 1'b1};
        vecs[5] = '{"empty", 25'd0, 1'b1, LIFE_B3, LIFE_S23, 25'd0, 5'd0, 1'b0};

        rst = 1'b1; start = 1'b0; wrap = 1'b0; birth_mask = LIFE_B3; surv_mask = LIFE_S23; prev = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst next", 64'(next), 64'd0);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst gen", 64'(gen_count), 64'd0);
        chk("rst live", 64'(live_count), 64'd0);
        chk("rst changed", 64'(changed), 64'd0);

        for (int i = 0; i < 6; i++) run_gen(vecs[i]);

        // start held high through the run, dropped before the done cycle
        @(negedge clk);
        prev = BL_H; wrap = 1'b0; birth_mask = LIFE_B3; surv_mask = LIFE_S23; start = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) ndone++;
        end
        gen_exp++;
        chk("held done count", 64'(ndone), 64'd1);
        chk("held gen", 64'(gen_count), 64'(gen_exp));
        chk("held next", 64'(next), 64'(BL_V));

        // back-to-back: restart in the done cycle, then scramble inputs mid-run
        @(negedge clk);
        prev = BL_H; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        chk("b2b first latency", 64'(k), 64'd5);
        chk("b2b first next", 64'(next), 64'(BL_V));
        prev = BL_V; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; prev = '1; wrap = 1'b1; birth_mask = '1; surv_mask = '1;
        wait_done(k);
        gen_exp += 2;
        chk("b2b second latency", 64'(k), 64'd5);
        chk("b2b second next", 64'(next), 64'(BL_H));
        chk("b2b live", 64'(live_count), 64'd3);
        chk("b2b changed", 64'(changed), 64'd1);
        chk("b2b gen", 64'(gen_count), 64'(gen_exp));

        // reset asserted at edge E3 of a run aborts it
        @(negedge clk);
        prev = BL_H; wrap = 1'b0; birth_mask = LIFE_B3; surv_mask = LIFE_S23; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", 64'(busy), 64'd0);
        chk("abort done", 64'(done), 64'd0);
        chk("abort next", 64'(next), 64'd0);
        chk("abort gen", 64'(gen_count), 64'd0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort no done", 64'(ndone), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
